i3c_pinm_in_sync: RTL and testbench

Input-side companion to the pad-near SDA output register. It brings the raw SCL and SDA pad inputs into the system clock domain through a synchronizer and a per-line spike filter. From the filtered lines it detects bus conditions (START, repeated START, STOP, SCL edges) and assembles serial bits into bytes plus the 9th (ACK/T) bit. It sits between the pads and the I3C peripheral's protocol state machine, which consumes only its single-cycle event pulses.

---
 rtl/i3c_pinm_pkg.sv | 10 +
 rtl/i3c_pinm_in_sync_if.sv | 32 +++
 rtl/i3c_pinm_glitch_filt.sv | 53 +++++
 rtl/i3c_pinm_in_sync.sv | 116 +++++++++++
 tb/tb_i3c_pinm_in_sync.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i3c_pinm_pkg.sv
// Shared constants for the I3C pin-side input path: bit counter and spike-filter sizing.
// No logic, no latency.
package i3c_pinm_pkg;

  localparam int BITCNT_W     = 4;
  localparam int BIT_LAST     = 8;
  localparam int FILT_CYC_MAX = 7;
  localparam int FILT_CNT_W   = $clog2(FILT_CYC_MAX + 1);

endpackage

// File: rtl/i3c_pinm_in_sync_if.sv
// Pad inputs, enable and event/level outputs of the I3C input synchronizer.
// master = peripheral/pad side that drives pads and ena; slave = the synchronizer.
interface i3c_pinm_in_sync_if;

  logic       i_pad_SCL;
  logic       i_pad_SDA;
  logic       ena;
  logic       scl_f;
  logic       sda_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic       byte_vld;
  logic [7:0] byte_data;
  logic       ninth_vld;
  logic       ninth_bit;

  modport master (
    output i_pad_SCL, i_pad_SDA, ena,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det,
           bus_busy, byte_vld, byte_data, ninth_vld, ninth_bit
  );

  modport slave (
    input  i_pad_SCL, i_pad_SDA, ena,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det,
           bus_busy, byte_vld, byte_data, ninth_vld, ninth_bit
  );

endinterface

// File: rtl/i3c_pinm_glitch_filt.sv
// One pad line: SYNC_STAGES-flop synchronizer then a FILT_CYC-cycle persistence filter.
// Latency SYNC_STAGES+FILT_CYC cycles; no backpressure, free-running.
module i3c_pinm_glitch_filt
  import i3c_pinm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic pad,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  // Idle bus is high, so the chain resets to 1 to avoid a false edge out of reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (FILT_CYC == 0) begin : g_bypass
    assign filt = sync;
  end else begin : g_filt
    logic [FILT_CNT_W-1:0] cnt;
    logic                  filt_q;

    // Flip on the FILT_CYC-th consecutive differing sample; any agreeing sample restarts the count.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        cnt    <= '0;
        filt_q <= 1'b1;
      end else if (sync == filt_q) begin
        cnt <= '0;
      end else if (cnt == FILT_CNT_W'(FILT_CYC - 1)) begin
        cnt    <= '0;
        filt_q <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt = filt_q;
  end

endmodule

// File: rtl/i3c_pinm_in_sync.sv
// SCL/SDA pad input path: filtered levels, START/STOP/edge pulses, byte + 9th-bit assembly.
// Pulses are registered, 1 cycle after the filtered change; no backpressure.
module i3c_pinm_in_sync
  import i3c_pinm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3
) (
  input logic               CLK,
  input logic               RSTn,
  i3c_pinm_in_sync_if.slave bus
);

  localparam logic [BITCNT_W-1:0] BIT_NINTH = BITCNT_W'(BIT_LAST);
  localparam logic [BITCNT_W-1:0] BIT_DATA  = BITCNT_W'(BIT_LAST - 1);

  logic                scl_f, sda_f, scl_d, sda_d;
  logic                rise_c, fall_c, start_c, stop_c;
  logic                scl_rise_q, scl_fall_q, start_q, stop_q;
  logic                busy_q, byte_vld_q, ninth_vld_q, ninth_q;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [6:0]          shift_q;
  logic [7:0]          byte_q;

  i3c_pinm_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_scl_filt (
    .CLK (CLK), .RSTn(RSTn), .pad(bus.i_pad_SCL), .filt(scl_f)
  );

  i3c_pinm_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_sda_filt (
    .CLK (CLK), .RSTn(RSTn), .pad(bus.i_pad_SDA), .filt(sda_f)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // Requiring SCL high in both cycles masks START/STOP when SCL and SDA move together.
  always_comb begin
    rise_c  = scl_f & ~scl_d;
    fall_c  = ~scl_f & scl_d;
    start_c = scl_f & scl_d & sda_d & ~sda_f;
    stop_c  = scl_f & scl_d & ~sda_d & sda_f;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_rise_q <= bus.ena & rise_c;
      scl_fall_q <= bus.ena & fall_c;
      start_q    <= bus.ena & start_c;
      stop_q     <= bus.ena & stop_c;
    end
  end

  // Bus conditions take priority over a coincident capture so a partial byte is dropped.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      busy_q      <= 1'b0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      ninth_vld_q <= 1'b0;
      ninth_q     <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      ninth_vld_q <= 1'b0;
      if (!bus.ena) begin
        busy_q  <= 1'b0;
        bit_cnt <= '0;
      end else if (start_c) begin
        busy_q  <= 1'b1;
        bit_cnt <= '0;
      end else if (stop_c) begin
        busy_q  <= 1'b0;
        bit_cnt <= '0;
      end else if (scl_rise_q && busy_q) begin
        if (bit_cnt == BIT_NINTH) begin
          ninth_q     <= sda_f;
          ninth_vld_q <= 1'b1;
          bit_cnt     <= '0;
        end else begin
          shift_q <= {shift_q[5:0], sda_f};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_DATA) begin
            byte_q     <= {shift_q, sda_f};
            byte_vld_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.scl_f     = scl_f;
  assign bus.sda_f     = sda_f;
  assign bus.scl_rise  = scl_rise_q;
  assign bus.scl_fall  = scl_fall_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.bus_busy  = busy_q;
  assign bus.byte_vld  = byte_vld_q;
  assign bus.byte_data = byte_q;
  assign bus.ninth_vld = ninth_vld_q;
  assign bus.ninth_bit = ninth_q;

endmodule

// File: tb/tb_i3c_pinm_in_sync.sv
// Directed bench for i3c_pinm_in_sync: per-cycle compare against a level/transaction model,
// plus literal checks on pulse counts and captured data.
module tb_i3c_pinm_in_sync;

  localparam int SYNC = 2;
  localparam int FILT = 3;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  i3c_pinm_in_sync_if bus();

  i3c_pinm_in_sync #(.SYNC_STAGES(SYNC), .FILT_CYC(FILT)) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // literal-check handoff: stimulus posts, compare process evaluates
  string       lit_name;
  logic [31:0] lit_act, lit_exp;
  int          lit_req = 0;
  int          lit_ack = 0;

  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_bvld = 0, n_nvld = 0;

  // ---------------- behavioural model ----------------
  // Pad history per line: bit k = pad sampled k edges ago. A filtered level flips once the
  // FILT samples that have crossed the synchronizer all disagree with it.
  bit [7:0] hs, hd;
  bit       m_sclf, m_sdaf, m_scld, m_sdad;
  bit       m_rise, m_fall, m_start, m_stop, m_busy, m_bvld, m_nvld, m_ninth;
  int       m_bit, m_acc;
  bit [7:0] m_byte;
  bit       ps1, ps2, pd1, pd2, prise;

  function automatic bit accept(bit [7:0] h, bit f);
    for (int i = SYNC; i < SYNC + FILT; i++)
      if (h[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hs = '1; hd = '1;
      m_sclf = 1; m_sdaf = 1; m_scld = 1; m_sdad = 1;
      m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
      m_busy = 0; m_bvld = 0; m_nvld = 0; m_ninth = 0;
      m_bit = 0; m_acc = 0; m_byte = 0;
    end else begin
      ps1 = m_sclf; ps2 = m_scld; pd1 = m_sdaf; pd2 = m_sdad; prise = m_rise;
      hs = {hs[6:0], bit'(bus.i_pad_SCL)};
      hd = {hd[6:0], bit'(bus.i_pad_SDA)};
      if (accept(hs, m_sclf)) m_sclf = ~m_sclf;
      if (accept(hd, m_sdaf)) m_sdaf = ~m_sdaf;
      m_scld = ps1;
      m_sdad = pd1;
      m_bvld = 0;
      m_nvld = 0;
      if (!bus.ena) begin
        m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
        m_busy = 0; m_bit = 0;
      end else begin
        m_rise  = ps1 && !ps2;
        m_fall  = !ps1 && ps2;
        m_start = ps1 && ps2 && pd2 && !pd1;
        m_stop  = ps1 && ps2 && !pd2 && pd1;
        if (m_start) begin
          m_busy = 1; m_bit = 0;
        end else if (m_stop) begin
          m_busy = 0; m_bit = 0;
        end else if (prise && m_busy) begin
          if (m_bit == 8) begin
            m_ninth = pd1; m_nvld = 1; m_bit = 0;
          end else begin
            m_acc = ((m_acc * 2) + int'(pd1)) % 256;
            m_bit++;
            if (m_bit == 8) begin
              m_byte = m_acc[7:0];
              m_bvld = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (lit_ack != lit_req) begin
      chk(lit_name, lit_act, lit_exp);
      lit_ack = lit_req;
    end
    chk("scl_f",     bus.scl_f,     m_sclf);
    chk("sda_f",     bus.sda_f,     m_sdaf);
    chk("scl_rise",  bus.scl_rise,  m_rise);
    chk("scl_fall",  bus.scl_fall,  m_fall);
    chk("start_det", bus.start_det, m_start);
    chk("stop_det",  bus.stop_det,  m_stop);
    chk("bus_busy",  bus.bus_busy,  m_busy);
    chk("byte_vld",  bus.byte_vld,  m_bvld);
    chk("byte_data", bus.byte_data, m_byte);
    chk("ninth_vld", bus.ninth_vld, m_nvld);
    chk("ninth_bit", bus.ninth_bit, m_ninth);
    if (bus.scl_rise  === 1'b1) n_rise++;
    if (bus.scl_fall  === 1'b1) n_fall++;
    if (bus.start_det === 1'b1) n_start++;
    if (bus.stop_det  === 1'b1) n_stop++;
    if (bus.byte_vld  === 1'b1) n_bvld++;
    if (bus.ninth_vld === 1'b1) n_nvld++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_name = n;
    lit_act  = a;
    lit_exp  = e;
    lit_req++;
    wait (lit_ack == lit_req);
    @(posedge CLK);
    #1;
  endtask

  function automatic int tot();
    return n_rise + n_fall + n_start + n_stop + n_bvld + n_nvld;
  endfunction

  task automatic send_bit(input logic b);
    bus.i_pad_SDA = b;    cyc(8);
    bus.i_pad_SCL = 1'b1; cyc(8);
    bus.i_pad_SCL = 1'b0; cyc(8);
  endtask

  task automatic do_start();
    bus.i_pad_SDA = 1'b1; cyc(8);
    bus.i_pad_SCL = 1'b1; cyc(8);
    bus.i_pad_SDA = 1'b0; cyc(8);
    bus.i_pad_SCL = 1'b0; cyc(8);
  endtask

  task automatic do_stop();
    bus.i_pad_SDA = 1'b0; cyc(8);
    bus.i_pad_SCL = 1'b1; cyc(8);
    bus.i_pad_SDA = 1'b1; cyc(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic nb);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_start, s_stop, s_bvld, s_nvld, s_rise, s_fall, s_tot;
    logic v4, v5;

    bus.i_pad_SCL = 1'b1;
    bus.i_pad_SDA = 1'b1;
    bus.ena       = 1'b1;
    cyc(3);

    // reset values
    lit("rst_scl_f",     bus.scl_f,     1);
    lit("rst_sda_f",     bus.sda_f,     1);
    lit("rst_bus_busy",  bus.bus_busy,  0);
    lit("rst_byte_data", bus.byte_data, 8'h00);
    lit("rst_ninth_bit", bus.ninth_bit, 0);
    RSTn = 1'b1;

    s_tot = tot();
    cyc(100);
    lit("idle_no_pulses", tot() - s_tot, 0);

    // spike filter: 1- and 2-cycle lows rejected, 3-cycle low accepted at cycle 5
    s_start = n_start; s_stop = n_stop;
    bus.i_pad_SDA = 1'b0; cyc(1); bus.i_pad_SDA = 1'b1; cyc(12);
    bus.i_pad_SDA = 1'b0; cyc(2); bus.i_pad_SDA = 1'b1; cyc(12);
    lit("glitch_no_start", n_start - s_start, 0);
    bus.i_pad_SDA = 1'b0; cyc(3); bus.i_pad_SDA = 1'b1;
    @(posedge CLK); @(negedge CLK); v4 = bus.sda_f;
    @(posedge CLK); @(negedge CLK); v5 = bus.sda_f;
    cyc(12);
    lit("filt3_cycle4_high", v4, 1);
    lit("filt3_cycle5_low",  v5, 0);
    lit("filt3_start_cnt",   n_start - s_start, 1);
    lit("filt3_stop_cnt",    n_stop - s_stop, 1);

    // START + 0xA5 + ninth 0
    s_start = n_start; s_bvld = n_bvld; s_nvld = n_nvld;
    do_start();
    send_byte(8'hA5, 1'b0);
    lit("a5_start_cnt", n_start - s_start, 1);
    lit("a5_bvld_cnt",  n_bvld - s_bvld, 1);
    lit("a5_nvld_cnt",  n_nvld - s_nvld, 1);
    lit("a5_byte",      bus.byte_data, 8'hA5);
    lit("a5_ninth",     bus.ninth_bit, 0);
    do_stop();
    cyc(4);

    // repeated START after 4 bits, then 0x3C + 1, STOP
    s_start = n_start; s_stop = n_stop; s_bvld = n_bvld;
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    do_start();
    lit("rs_partial_no_bvld", n_bvld - s_bvld, 0);
    send_byte(8'h3C, 1'b1);
    do_stop();
    cyc(4);
    lit("rs_start_cnt", n_start - s_start, 2);
    lit("rs_bvld_cnt",  n_bvld - s_bvld, 1);
    lit("rs_byte",      bus.byte_data, 8'h3C);
    lit("rs_ninth",     bus.ninth_bit, 1);
    lit("rs_stop_cnt",  n_stop - s_stop, 1);
    lit("rs_busy_after_stop", bus.bus_busy, 0);

    // SCL and SDA moving together: only SCL edges reported
    s_start = n_start; s_stop = n_stop; s_rise = n_rise; s_fall = n_fall;
    bus.i_pad_SCL = 1'b0; bus.i_pad_SDA = 1'b0; cyc(10);
    bus.i_pad_SCL = 1'b1; bus.i_pad_SDA = 1'b1; cyc(10);
    lit("simul_fall_cnt",  n_fall - s_fall, 1);
    lit("simul_rise_cnt",  n_rise - s_rise, 1);
    lit("simul_start_cnt", n_start - s_start, 0);
    lit("simul_stop_cnt",  n_stop - s_stop, 0);

    // reset mid-byte, then a clean 0xFF transfer
    do_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    RSTn = 1'b0;
    bus.i_pad_SCL = 1'b1; bus.i_pad_SDA = 1'b1;
    cyc(4);
    lit("midrst_byte_cleared", bus.byte_data, 8'h00);
    lit("midrst_busy_cleared", bus.bus_busy, 0);
    RSTn = 1'b1;
    cyc(10);
    s_bvld = n_bvld;
    do_start();
    send_byte(8'hFF, 1'b0);
    do_stop();
    cyc(4);
    lit("ff_bvld_cnt", n_bvld - s_bvld, 1);
    lit("ff_byte",     bus.byte_data, 8'hFF);

    // ena=0 throughout a full transfer
    bus.ena = 1'b0;
    s_tot = tot();
    do_start();
    send_byte(8'h5A, 1'b1);
    do_stop();
    cyc(4);
    lit("dis_no_pulses",  tot() - s_tot, 0);
    lit("dis_byte_held",  bus.byte_data, 8'hFF);
    lit("dis_ninth_held", bus.ninth_bit, 0);

    // re-enable after START: no capture until the next START
    s_bvld = n_bvld; s_nvld = n_nvld; s_stop = n_stop;
    do_start();
    bus.ena = 1'b1;
    send_byte(8'h12, 1'b0);
    do_stop();
    cyc(4);
    lit("reen_bvld_cnt", n_bvld - s_bvld, 0);
    lit("reen_nvld_cnt", n_nvld - s_nvld, 0);
    lit("reen_stop_cnt", n_stop - s_stop, 1);

    cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
